// File: rtl/alu_ctrl_mc_if.sv
// rtl/alu_ctrl_mc_if.sv - request/response bundle between decode stage, ALU controller and writeback
interface alu_ctrl_mc_if #(
    parameter int WIDTH   = 32,
    parameter int FUNCT_W = 6
);
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         aluop;
    logic [FUNCT_W-1:0] funct;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   result;
    logic               zero;
    logic               ovf;
    logic               illegal;
    logic               busy;

    // Producer of requests / consumer of results
    modport master (
        output in_valid, aluop, funct, a, b, out_ready,
        input  in_ready, out_valid, result, zero, ovf, illegal, busy
    );

    // The ALU controller itself
    modport slave (
        input  in_valid, aluop, funct, a, b, out_ready,
        output in_ready, out_valid, result, zero, ovf, illegal, busy
    );
endinterface

// File: rtl/alu_ctrl_mc.sv
// rtl/alu_ctrl_mc.sv - multi-cycle ALU controller; iterative MULT/DIVU built only with ALU_MULDIV_EN
module alu_ctrl_mc #(
    parameter int WIDTH   = 32,
    parameter int FUNCT_W = 6
) (
    input logic          clk,
    input logic          rst_n,
    alu_ctrl_mc_if.slave bus
);

    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL, OP_DIV, OP_ILL
    } op_e;

`ifdef ALU_MULDIV_EN
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_e;
    localparam int CNT_W = $clog2(WIDTH);
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_e;
`endif

    state_e           state_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             ovf_q;
    logic             illegal_q;
    logic             out_valid_q;
    logic             busy_q;
    logic             in_ready_q;

    op_e              op;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] dif;
    logic [WIDTH-1:0] res1_d;
    logic             ovf1_d;
    logic             ill1_d;
    logic             go_exec;

`ifdef ALU_MULDIV_EN
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] opa_q;      // MULT: shifted multiplicand, DIVU: dividend/quotient shifter
    logic [WIDTH-1:0] opb_q;      // MULT: shifted multiplier,   DIVU: divisor
    logic [WIDTH-1:0] acc_q;      // MULT: partial product,      DIVU: partial remainder
    logic             is_div_q;

    logic [WIDTH-1:0] mul_acc_d;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH-1:0] div_rem_d;
    logic [WIDTH-1:0] div_quo_d;
    logic [WIDTH-1:0] fin_res_d;

    // One shift-add or one restoring-division step from the current iteration registers
    always_comb begin
        mul_acc_d = acc_q + (opb_q[0] ? opa_q : '0);
        div_shift = {acc_q, opa_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opb_q};
        div_rem_d = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
        div_quo_d = {opa_q[WIDTH-2:0], ~div_diff[WIDTH]};
        fin_res_d = is_div_q ? div_quo_d : mul_acc_d;
    end
`endif

    // Decode aluop/funct and compute every single-cycle result from the live request
    always_comb begin
        op = OP_ILL;
        case (bus.aluop)
            2'b00: op = OP_ADD;
            2'b01: op = OP_SUB;
            2'b10: begin
                // funct bits above [5:0] must be clear for any legal code
                if ((bus.funct >> 6) == '0) begin
                    case (bus.funct[5:0])
                        6'b100000: op = OP_ADD;
                        6'b100010: op = OP_SUB;
                        6'b100100: op = OP_AND;
                        6'b100101: op = OP_OR;
                        6'b101010: op = OP_SLT;
`ifdef ALU_MULDIV_EN
                        6'b011000: op = OP_MUL;
                        6'b011010: op = OP_DIV;
`endif
                        default:   op = OP_ILL;
                    endcase
                end
            end
            default: op = OP_ILL;
        endcase

        sum     = bus.a + bus.b;
        dif     = bus.a - bus.b;
        res1_d  = '0;
        ovf1_d  = 1'b0;
        ill1_d  = 1'b0;
        go_exec = 1'b0;
        case (op)
            OP_ADD: begin
                res1_d = sum;
                ovf1_d = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                res1_d = dif;
                ovf1_d = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (dif[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_AND: res1_d = bus.a & bus.b;
            OP_OR:  res1_d = bus.a | bus.b;
            OP_SLT: res1_d = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_MUL: go_exec = 1'b1;
            // Divide by zero short-circuits to all ones without iterating
            OP_DIV: begin
                res1_d  = '1;
                go_exec = (bus.b != '0);
            end
            default: begin
                res1_d = '0;
                ill1_d = 1'b1;
            end
        endcase
    end

    // Control FSM with registered outputs and iteration datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            result_q    <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
`ifdef ALU_MULDIV_EN
            cnt_q       <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            acc_q       <= '0;
            is_div_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        busy_q     <= 1'b1;
                        in_ready_q <= 1'b0;
`ifdef ALU_MULDIV_EN
                        if (go_exec) begin
                            state_q  <= EXEC;
                            cnt_q    <= CNT_W'(WIDTH - 1);
                            opa_q    <= bus.a;
                            opb_q    <= bus.b;
                            acc_q    <= '0;
                            is_div_q <= (op == OP_DIV);
                        end else
`endif
                        begin
                            state_q     <= DONE;
                            result_q    <= res1_d;
                            zero_q      <= (res1_d == '0);
                            ovf_q       <= ovf1_d;
                            illegal_q   <= ill1_d;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
`ifdef ALU_MULDIV_EN
                EXEC: begin
                    if (is_div_q) begin
                        acc_q <= div_rem_d;
                        opa_q <= div_quo_d;
                    end else begin
                        acc_q <= mul_acc_d;
                        opa_q <= opa_q << 1;
                        opb_q <= opb_q >> 1;
                    end
                    // Exit on the last step rather than letting the counter wrap
                    if (cnt_q == '0) begin
                        state_q     <= DONE;
                        result_q    <= fin_res_d;
                        zero_q      <= (fin_res_d == '0);
                        ovf_q       <= 1'b0;
                        illegal_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
`endif
                DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.ovf       = ovf_q;
    assign bus.illegal   = illegal_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_alu_ctrl_mc.sv
// tb/tb_alu_ctrl_mc.sv - self-checking bench for alu_ctrl_mc (vector table, random ops vs reference model)
module tb_alu_ctrl_mc;
    localparam int W = 32;

`ifdef ALU_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    typedef struct {
        logic [1:0]   op;
        logic [5:0]   f;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        bit           z;
        bit           ov;
        bit           il;
        int           lat;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    alu_ctrl_mc_if #(.WIDTH(W), .FUNCT_W(6)) bus ();

    alu_ctrl_mc #(.WIDTH(W), .FUNCT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference behaviour from the operation definitions, using wide integer arithmetic
    task automatic model(input logic [1:0] op, input logic [5:0] f, input logic [W-1:0] a,
                         input logic [W-1:0] b, output logic [W-1:0] r, output bit z,
                         output bit ov, output bit il, output int lat);
        longint sa, sb, s;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        r   = '0;
        ov  = 0;
        il  = 0;
        lat = 1;
        if (op == 2'b00 || (op == 2'b10 && f == 6'h20)) begin
            s  = sa + sb;
            r  = s[W-1:0];
            ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end else if (op == 2'b01 || (op == 2'b10 && f == 6'h22)) begin
            s  = sa - sb;
            r  = s[W-1:0];
            ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end else if (op == 2'b10 && f == 6'h24) r = a & b;
        else if (op == 2'b10 && f == 6'h25) r = a | b;
        else if (op == 2'b10 && f == 6'h2A) r = (sa < sb) ? 1 : 0;
        else if (MD && op == 2'b10 && f == 6'h18) begin
            r   = W'(a * b);
            lat = W + 1;
        end else if (MD && op == 2'b10 && f == 6'h1A) begin
            if (b == 0) r = '1;
            else begin
                r   = a / b;
                lat = W + 1;
            end
        end else il = 1;
        z = (r == 0);
    endtask

    // All drive/sample activity happens 1 time unit after a rising edge
    task automatic send(input logic [1:0] op, input logic [5:0] f, input logic [W-1:0] a,
                        input logic [W-1:0] b);
        chk("in_ready_before_accept", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.aluop    = op;
        bus.funct    = f;
        bus.a        = a;
        bus.b        = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a        = $urandom;
        bus.b        = $urandom;
        bus.aluop    = 2'($urandom);
        bus.funct    = 6'($urandom);
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic check_out(input string tag, input logic [W-1:0] r, input bit z, input bit ov,
                             input bit il, input int lat_exp, input int lat);
        chk({tag, "_latency"}, lat, lat_exp);
        chk({tag, "_result"},  bus.result, r);
        chk({tag, "_zero"},    bus.zero, z);
        chk({tag, "_ovf"},     bus.ovf, ov);
        chk({tag, "_illegal"}, bus.illegal, il);
        chk({tag, "_in_ready_done"}, bus.in_ready, 0);
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("out_valid_after_take", bus.out_valid, 0);
        chk("busy_after_take", bus.busy, 0);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_in_ready"},  bus.in_ready, 1);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_busy"},      bus.busy, 0);
        chk({tag, "_result"},    bus.result, 0);
        chk({tag, "_zero"},      bus.zero, 0);
        chk({tag, "_ovf"},       bus.ovf, 0);
        chk({tag, "_illegal"},   bus.illegal, 0);
    endtask

    initial begin
        vec_t         vt[$];
        logic [5:0]   codes[8];
        logic [W-1:0] r, held;
        bit           z, ov, il;
        int           lat, lat_exp;
        logic [1:0]   op;
        logic [5:0]   f;
        logic [W-1:0] a, b;

        n_vec = 0;
        n_err = 0;

        vt.push_back('{2'b10, 6'h20, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 0, 1, 0, 1});
        vt.push_back('{2'b01, 6'h00, 32'h5,         32'h5,         32'h0,         1, 0, 0, 1});
        vt.push_back('{2'b10, 6'h2A, 32'hFFFF_FFFF, 32'h1,         32'h1,         0, 0, 0, 1});
        vt.push_back('{2'b10, 6'h2A, 32'h1,         32'hFFFF_FFFF, 32'h0,         1, 0, 0, 1});
        vt.push_back('{2'b00, 6'h3F, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 0, 0, 0, 1});
        vt.push_back('{2'b10, 6'h22, 32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 0, 1, 0, 1});
        vt.push_back('{2'b10, 6'h24, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0, 0, 0, 1});
        vt.push_back('{2'b10, 6'h25, 32'hF0F0_F0F0, 32'h0F00_0F00, 32'hFFF0_FFF0, 0, 0, 0, 1});
        vt.push_back('{2'b11, 6'h20, 32'h1,         32'h2,         32'h0,         1, 0, 1, 1});
        vt.push_back('{2'b10, 6'h3F, 32'h1,         32'h2,         32'h0,         1, 0, 1, 1});
        vt.push_back('{2'b00, 6'h00, 32'hFFFF_FFFF, 32'h1,         32'h0,         1, 0, 0, 1});
`ifdef ALU_MULDIV_EN
        vt.push_back('{2'b10, 6'h18, 32'h0001_0003, 32'h5,         32'h0005_000F, 0, 0, 0, 33});
        vt.push_back('{2'b10, 6'h1A, 32'h100,       32'h7,         32'h24,        0, 0, 0, 33});
        vt.push_back('{2'b10, 6'h1A, 32'h100,       32'h0,         32'hFFFF_FFFF, 0, 0, 0, 1});
        vt.push_back('{2'b10, 6'h1A, 32'h3,         32'h7,         32'h0,         1, 0, 0, 33});
`else
        vt.push_back('{2'b10, 6'h18, 32'h0001_0003, 32'h5,         32'h0,         1, 0, 1, 1});
        vt.push_back('{2'b10, 6'h1A, 32'h100,       32'h7,         32'h0,         1, 0, 1, 1});
`endif

        codes = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h18, 6'h1A, 6'h00};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.aluop     = 2'b00;
        bus.funct     = 6'h00;
        bus.a         = '0;
        bus.b         = '0;
        rst_n         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_checks("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vt[i]) begin
            send(vt[i].op, vt[i].f, vt[i].a, vt[i].b);
            wait_out(lat);
            check_out($sformatf("vec%0d", i), vt[i].r, vt[i].z, vt[i].ov, vt[i].il, vt[i].lat, lat);
            release_out();
        end

        // Consumer stalls 10 cycles in DONE while a new request is offered
        send(2'b00, 6'h00, 32'h10, 32'h20);
        wait_out(lat);
        held = bus.result;
        chk("stall_first_result", held, 32'h30);
        bus.in_valid = 1'b1;
        bus.aluop    = 2'b01;
        bus.a        = 32'h99;
        bus.b        = 32'h1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            chk($sformatf("stall%0d_out_valid", k), bus.out_valid, 1);
            chk($sformatf("stall%0d_result", k), bus.result, 32'h30);
            chk($sformatf("stall%0d_in_ready", k), bus.in_ready, 0);
        end
        bus.in_valid = 1'b0;
        release_out();
        chk("stall_in_ready_after", bus.in_ready, 1);

        // Reset while holding a result in DONE
        send(2'b10, 6'h3F, 32'h1, 32'h1);
        wait_out(lat);
        rst_n = 1'b0;
        #1;
        reset_checks("rst_in_done");
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

`ifdef ALU_MULDIV_EN
        // Reset ten cycles into a MULT, then a normal ADD
        send(2'b10, 6'h18, 32'h0001_0003, 32'h5);
        repeat (9) @(posedge clk);
        #1;
        chk("mult_busy_mid_exec", bus.busy, 1);
        chk("mult_out_valid_mid_exec", bus.out_valid, 0);
        rst_n = 1'b0;
        #1;
        reset_checks("rst_in_exec");
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        repeat (40) begin
            @(posedge clk); #1;
            chk("no_result_after_abort", bus.out_valid, 0);
        end
`endif
        send(2'b00, 6'h00, 32'h0000_0100, 32'h0000_0023);
        wait_out(lat);
        check_out("add_after_reset", 32'h123, 0, 0, 0, 1, lat);
        release_out();

        // Random requests against the reference model
        for (int n = 0; n < 200; n++) begin
            op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) op = 2'b10;
            f  = ($urandom_range(0, 7) == 7) ? 6'($urandom) : codes[$urandom_range(0, 7)];
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = '0;
                1:       b = W'($urandom_range(1, 255));
                default: b = $urandom;
            endcase
            model(op, f, a, b, r, z, ov, il, lat_exp);
            send(op, f, a, b);
            wait_out(lat);
            check_out($sformatf("rnd%0d_op%0d_f%0h", n, op, f), r, z, ov, il, lat_exp, lat);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
                chk("rnd_hold_result", bus.result, r);
            end
            release_out();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
